beep_scheduler: RTL and testbench

//   Sequences the tone driver's en_500/en_1k enables for two requesters:
//   the hourly chime and the alarm clock.
//   - Chime pattern: CHIME_LOW_BEEPS one-second 500 Hz beeps, each followed
//     by a one-second gap, then one one-second 1 kHz beep.
//   - Alarm pattern: continuous 1 kHz for ALARM_SECS seconds, or until stopped.

---
 rtl/beep_scheduler_if.sv | 23 ++
 rtl/beep_scheduler.sv | 110 +++++++++++
 tb/tb_beep_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/beep_scheduler_if.sv
// Request/enable bundle between the timekeeping logic, beep_scheduler and the tone driver.
// The master side issues ticks and requests; the slave side (the scheduler) returns the tone enables and status.
interface beep_scheduler_if;
    logic tick_1s;
    logic req_chime;
    logic req_alarm;
    logic stop_alarm;
    logic mute;
    logic en_500;
    logic en_1k;
    logic busy;
    logic alarm_on;

    modport master (
        output tick_1s, req_chime, req_alarm, stop_alarm, mute,
        input  en_500, en_1k, busy, alarm_on
    );

    modport slave (
        input  tick_1s, req_chime, req_alarm, stop_alarm, mute,
        output en_500, en_1k, busy, alarm_on
    );
endinterface

// File: rtl/beep_scheduler.sv
// Hourly-chime and alarm sequencer: drives the tone driver's 500 Hz / 1 kHz enables,
// stepping once per tick_1s. Alarm requests pre-empt any chime in progress.
module beep_scheduler #(
    parameter int CHIME_LOW_BEEPS = 4,
    parameter int ALARM_SECS      = 60
) (
    input  logic             clk,
    input  logic             rst,
    beep_scheduler_if.slave  bus
);
    localparam int BEEP_W = $clog2(CHIME_LOW_BEEPS + 1);
    localparam int SEC_W  = $clog2(ALARM_SECS + 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(CHIME_LOW_BEEPS);
    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(ALARM_SECS - 1);

    typedef enum logic [2:0] {IDLE, CH_LOW, CH_GAP, CH_HIGH, ALARM} state_t;

    state_t            state, nxt;
    logic [BEEP_W-1:0] beep_cnt, beep_nxt;
    logic [SEC_W-1:0]  sec_cnt, sec_nxt;
    logic              low_flag, high_flag, busy_flag, alarm_flag;

    always_comb begin
        nxt      = state;
        beep_nxt = beep_cnt;
        sec_nxt  = sec_cnt;
        case (state)
            IDLE: begin
                if (bus.req_alarm) begin
                    nxt     = ALARM;
                    sec_nxt = '0;
                end else if (bus.req_chime) begin
                    nxt      = CH_LOW;
                    beep_nxt = BEEP_W'(1);
                end
            end
            CH_LOW, CH_GAP, CH_HIGH: begin
                // An alarm abandons the chime outright, even on a tick cycle.
                if (bus.req_alarm) begin
                    nxt      = ALARM;
                    sec_nxt  = '0;
                    beep_nxt = '0;
                end else if (bus.tick_1s) begin
                    case (state)
                        CH_LOW: nxt = CH_GAP;
                        CH_GAP: begin
                            if (beep_cnt == BEEP_LAST) begin
                                nxt = CH_HIGH;
                            end else begin
                                nxt      = CH_LOW;
                                beep_nxt = beep_cnt + BEEP_W'(1);
                            end
                        end
                        default: begin
                            nxt      = IDLE;
                            beep_nxt = '0;
                        end
                    endcase
                end
            end
            ALARM: begin
                if (bus.stop_alarm) begin
                    nxt     = IDLE;
                    sec_nxt = '0;
                end else if (bus.req_alarm) begin
                    sec_nxt = '0;
                end else if (bus.tick_1s) begin
                    // This tick completes the final second of the alarm.
                    if (sec_cnt == SEC_LAST) begin
                        nxt     = IDLE;
                        sec_nxt = '0;
                    end else begin
                        sec_nxt = sec_cnt + SEC_W'(1);
                    end
                end
            end
            default: begin
                nxt      = IDLE;
                beep_nxt = '0;
                sec_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beep_cnt   <= '0;
            sec_cnt    <= '0;
            low_flag   <= 1'b0;
            high_flag  <= 1'b0;
            busy_flag  <= 1'b0;
            alarm_flag <= 1'b0;
        end else begin
            state      <= nxt;
            beep_cnt   <= beep_nxt;
            sec_cnt    <= sec_nxt;
            low_flag   <= (nxt == CH_LOW);
            high_flag  <= (nxt == CH_HIGH) || (nxt == ALARM);
            busy_flag  <= (nxt != IDLE);
            alarm_flag <= (nxt == ALARM);
        end
    end

    // Mute gates the registered tone flags directly so it takes effect in the same cycle.
    assign bus.en_500   = low_flag  & ~bus.mute;
    assign bus.en_1k    = high_flag & ~bus.mute;
    assign bus.busy     = busy_flag;
    assign bus.alarm_on = alarm_flag;
endmodule

// File: tb/tb_beep_scheduler.sv
// Scoreboard bench for beep_scheduler: a second-by-second chime/alarm model predicts the
// outputs of every cycle, and an independent monitor compares them on the falling edge.
module tb_beep_scheduler;
    localparam int N_LOW = 4;
    localparam int A_SECS = 3;
    localparam int TP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    beep_scheduler_if bus ();

    beep_scheduler #(.CHIME_LOW_BEEPS(N_LOW), .ALARM_SECS(A_SECS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [3:0] sb[$];

    // Model: mode 0 idle, 1 chime, 2 alarm; ticks counted since the sequence started.
    int mode = 0;
    int chime_ticks = 0;
    int alarm_ticks = 0;

    function automatic void model_step(bit r, bit t, bit rc, bit ra, bit sp);
        if (r) begin
            mode = 0;
        end else if (mode == 0) begin
            if (ra) begin mode = 2; alarm_ticks = 0; end
            else if (rc) begin mode = 1; chime_ticks = 0; end
        end else if (mode == 1) begin
            if (ra) begin mode = 2; alarm_ticks = 0; end
            else if (t) begin
                chime_ticks++;
                if (chime_ticks > 2 * N_LOW) mode = 0;
            end
        end else begin
            if (sp) mode = 0;
            else if (ra) alarm_ticks = 0;
            else if (t) begin
                alarm_ticks++;
                if (alarm_ticks >= A_SECS) mode = 0;
            end
        end
    endfunction

    function automatic logic [3:0] model_out(bit mu);
        bit lo, hi;
        lo = (mode == 1) && (chime_ticks < 2 * N_LOW) && (chime_ticks % 2 == 0);
        hi = ((mode == 1) && (chime_ticks == 2 * N_LOW)) || (mode == 2);
        return {lo & ~mu, hi & ~mu, mode != 0, mode == 2};
    endfunction

    task automatic drive(input bit rc, input bit ra, input bit sp, input bit mu, input bit r);
        @(posedge clk);
        #1;
        model_step(rst, bus.tick_1s, bus.req_chime, bus.req_alarm, bus.stop_alarm);
        cyc++;
        rst            = r;
        bus.tick_1s    = (cyc % TP == 0);
        bus.req_chime  = rc;
        bus.req_alarm  = ra;
        bus.stop_alarm = sp;
        bus.mute       = mu;
        sb.push_back(model_out(mu));
    endtask

    task automatic idle(input int n, input bit mu = 1'b0);
        for (int i = 0; i < n; i++) drive(0, 0, 0, mu, 0);
    endtask

    // Leave the bench so that the next drive() call lands on a tick cycle.
    task automatic align(input bit mu = 1'b0);
        while (((cyc + 1) % TP) != 0) drive(0, 0, 0, mu, 0);
    endtask

    initial begin : monitor
        logic [3:0] want, got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                want = sb.pop_front();
                got  = {bus.en_500, bus.en_1k, bus.busy, bus.alarm_on};
                n_cmp++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL outputs cyc=%0d {en_500,en_1k,busy,alarm_on} got %b want %b", cyc, got, want);
                end
                n_cmp++;
                if (bus.en_500 === 1'b1 && bus.en_1k === 1'b1) begin
                    n_bad++;
                    $display("FAIL exclusive cyc=%0d en_500=%b en_1k=%b want not both 1", cyc, bus.en_500, bus.en_1k);
                end
            end
        end
    end

    initial begin
        bus.tick_1s = 0; bus.req_chime = 0; bus.req_alarm = 0;
        bus.stop_alarm = 0; bus.mute = 0;
        // Reset, then reset again while the alarm is sounding.
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        idle(3);
        drive(0, 1, 0, 0, 0);
        idle(5);
        drive(0, 0, 0, 0, 1);
        idle(2 * TP);
        // Full chime started on a tick.
        align();
        drive(1, 0, 0, 0, 0);
        idle(9 * TP + 3);
        // Alarm with a chime request dropped mid-way.
        drive(0, 1, 0, 0, 0);
        idle(TP + 1);
        drive(1, 0, 0, 0, 0);
        idle(4 * TP);
        // Alarm pre-empts a chime in its second gap.
        align();
        drive(1, 0, 0, 0, 0);
        idle(3 * TP + 1);
        drive(0, 1, 0, 0, 0);
        idle(4 * TP);
        // Simultaneous alarm and chime requests from idle.
        drive(1, 1, 0, 0, 0);
        idle(4 * TP);
        // Stop coincident with a tick, then a stray stop while idle.
        drive(0, 1, 0, 0, 0);
        align();
        drive(0, 0, 1, 0, 0);
        idle(3);
        drive(0, 0, 1, 0, 0);
        idle(3);
        // Muted chime, then a chime with mute released during the 1 kHz beep.
        align(1);
        drive(1, 0, 0, 1, 0);
        idle(9 * TP + 3, 1);
        align(1);
        drive(1, 0, 0, 1, 0);
        idle(8 * TP + 1, 1);
        idle(TP + 2, 0);
        // Chime started off a tick: first beep shortened.
        idle(1);
        drive(1, 0, 0, 0, 0);
        idle(10 * TP);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit rc, ra, sp, mu, r;
            rc = ($urandom_range(0, 19) == 0);
            ra = ($urandom_range(0, 49) == 0);
            sp = !ra && ($urandom_range(0, 29) == 0);
            mu = ($urandom_range(0, 15) == 0) ? !bus.mute : bus.mute;
            r  = ($urandom_range(0, 399) == 0);
            drive(rc, ra, sp, mu, r);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain leftover=%0d want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
